// File: rtl/fifo_ctrl_64x8.sv
// Synchronous FIFO controller for an external 64x8 dual-port RAM with registered read data.
// Pointers carry an extra wrap bit so full and empty are told apart without a separate counter.
module fifo_ctrl_64x8 #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_write_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_read_addr,
  input  logic [DATA_W-1:0] ram_q
);

  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic            wr_acc;
  logic            rd_acc;

  // Status comes only from the registered pointers, so it never glitches on inputs.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign count = wr_ptr - rd_ptr;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  assign ram_we         = wr_acc;
  assign ram_data       = wr_data;
  assign ram_write_addr = wr_ptr[ADDR_W-1:0];
  assign ram_read_addr  = rd_ptr[ADDR_W-1:0];

  // The RAM registers its output, so ram_q lines up with rd_valid one cycle after the accept.
  assign rd_data = ram_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
      if (rd_acc) rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
      rd_valid  <= rd_acc;
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl_64x8.sv
// Bench for fifo_ctrl_64x8: behavioural RAM plus a queue-based reference model,
// directed boundary scenarios followed by a randomized traffic phase.
module tb_fifo_ctrl_64x8;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic [6:0] count;
  logic       overflow;
  logic       underflow;
  logic       ram_we;
  logic [5:0] ram_write_addr;
  logic [7:0] ram_data;
  logic [5:0] ram_read_addr;
  logic [7:0] ram_q;

  fifo_ctrl_64x8 #(.DATA_W(8), .ADDR_W(6)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .full           (full),
    .empty          (empty),
    .count          (count),
    .overflow       (overflow),
    .underflow      (underflow),
    .ram_we         (ram_we),
    .ram_write_addr (ram_write_addr),
    .ram_data       (ram_data),
    .ram_read_addr  (ram_read_addr),
    .ram_q          (ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 64x8 RAM, both ports on clk, registered read output.
  logic [7:0] mem [64];
  always @(posedge clk) begin
    if (ram_we) mem[ram_write_addr] <= ram_data;
    ram_q <= mem[ram_read_addr];
  end

  int tests = 0;
  int fails = 0;
  logic [7:0] model [$];
  int wr_total = 0;
  int rd_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock of traffic: pre-edge checks of status and RAM drive, post-edge checks of strobes.
  task automatic step(input logic w, input logic [7:0] wd, input logic r);
    int         sz;
    logic       exp_v;
    logic       exp_ov;
    logic       exp_un;
    logic       exp_we;
    logic [7:0] exp_d;
    wr_en = w; wr_data = wd; rd_en = r;
    #1;
    sz = model.size();
    exp_we = w && (sz < 64);
    exp_v  = r && (sz > 0);
    exp_ov = w && (sz == 64);
    exp_un = r && (sz == 0);
    exp_d  = 8'h00;
    chk("count", 32'(count), 32'(sz));
    chk("full", 32'(full), 32'(sz == 64));
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("ram_we", 32'(ram_we), 32'(exp_we));
    chk("ram_write_addr", 32'(ram_write_addr), 32'(wr_total % 64));
    chk("ram_read_addr", 32'(ram_read_addr), 32'(rd_total % 64));
    if (w) chk("ram_data", 32'(ram_data), 32'(wd));
    if (exp_v) begin
      exp_d = model.pop_front();
      rd_total++;
    end
    if (exp_we) begin
      model.push_back(wd);
      wr_total++;
    end
    @(posedge clk);
    #1;
    chk("rd_valid", 32'(rd_valid), 32'(exp_v));
    chk("overflow", 32'(overflow), 32'(exp_ov));
    chk("underflow", 32'(underflow), 32'(exp_un));
    if (exp_v) chk("rd_data", 32'(rd_data), 32'(exp_d));
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  // Asserts reset between edges and checks the outputs change without a clock.
  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    #1;
    model.delete();
    wr_total = 0;
    rd_total = 0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
    @(posedge clk);
    #1;
    do_reset();

    // Fill to 64, then one rejected write.
    for (int i = 0; i < 64; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'hEE, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    // Drain in order, then one rejected read.
    for (int i = 0; i < 64; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Address wrap 63 -> 0.
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 50; i++) step(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 50; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Simultaneous traffic at count 10.
    for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1);

    // Simultaneous at empty: write taken, read rejected.
    step(1'b1, 8'h3C, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Simultaneous at full: read taken, write rejected.
    for (int i = 0; i < 64; i++) step(1'b1, 8'($urandom), 1'b0);
    step(1'b1, 8'h77, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 63; i++) step(1'b0, 8'h00, 1'b1);

    // Reset at count 30 with a read strobe pending, then a fresh word.
    for (int i = 0; i < 31; i++) step(1'b1, 8'($urandom), 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk("pending_valid_before_reset", 32'(rd_valid), 32'd1);
    do_reset();
    step(1'b1, 8'hA5, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Randomized traffic, biased phases so both full and empty are visited.
    for (int i = 0; i < 600; i++) begin
      int wp;
      wp = ((i / 100) % 2 == 0) ? 75 : 25;
      step(($urandom_range(0, 99) < wp), 8'($urandom), ($urandom_range(0, 99) < 100 - wp));
    end
    step(1'b0, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl_64x8.md
FIFO_CTRL_64X8 -- requirements
Module: fifo_ctrl_64x8

Interface
REQ-001 Parameter: DATA_W, 8, word width; SHALL match the attached RAM word width.
REQ-002 Parameter: ADDR_W, 6, RAM address width; depth is 2**ADDR_W = 64 words.
REQ-003 Port: clk  input  1  single clock for all state; ports below are sampled or driven on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: wr_en  input  1  write request.
REQ-006 Port: wr_data  input  DATA_W  write word.
REQ-007 Port: rd_en  input  1  read request.
REQ-008 Port: rd_data  output  DATA_W  read word; meaningful only while rd_valid=1.
REQ-009 Port: rd_valid  output  1  one-cycle strobe marking rd_data valid.
REQ-010 Port: full  output  1  64 words stored.
REQ-011 Port: empty  output  1  0 words stored.
REQ-012 Port: count  output  ADDR_W+1  words stored, range 0..64.
REQ-013 Port: overflow  output  1  one-cycle pulse on a rejected write.
REQ-014 Port: underflow  output  1  one-cycle pulse on a rejected read.
REQ-015 Port: ram_we  output  1  RAM write enable.
REQ-016 Port: ram_write_addr  output  ADDR_W  RAM write address.
REQ-017 Port: ram_data  output  DATA_W  RAM write data.
REQ-018 Port: ram_read_addr  output  ADDR_W  RAM read address.
REQ-019 Port: ram_q  input  DATA_W  RAM registered read data; 1-cycle latency.
REQ-020 The RAM's read_clk and write_clk SHALL both connect to clk.

Function
REQ-021 Pointers: wr_ptr and rd_ptr are each ADDR_W+1 bits; the MSB is the wrap bit.
REQ-022 Pointer wrap: 127 -> 0; RAM address = ptr[ADDR_W-1:0], wrapping 63 -> 0.
REQ-023 Write accept: a write SHALL be accepted iff wr_en=1 and full=0; full is the value before the edge.
REQ-024 Read accept: a read SHALL be accepted iff rd_en=1 and empty=0; empty is the value before the edge.
REQ-025 A write on a full FIFO SHALL be rejected, even with a simultaneous accepted read.
REQ-026 A read on an empty FIFO SHALL be rejected, even with a simultaneous write.
REQ-027 ram_we SHALL equal (wr_en & ~full), combinationally.
REQ-028 ram_data SHALL equal wr_data, combinationally.
REQ-029 ram_write_addr SHALL equal wr_ptr[ADDR_W-1:0].
REQ-030 ram_read_addr SHALL equal rd_ptr[ADDR_W-1:0].
REQ-031 Each accepted write increments wr_ptr by 1; each accepted read increments rd_ptr by 1.
REQ-032 Read latency: rd_valid SHALL be 1 exactly in the cycle after an accepted read, and 0 otherwise.
REQ-033 rd_data SHALL equal ram_q.
REQ-034 count SHALL equal wr_ptr - rd_ptr, modulo 2**(ADDR_W+1).
REQ-035 Simultaneous accepted write and read SHALL leave count unchanged.
REQ-036 empty SHALL be 1 iff wr_ptr == rd_ptr.
REQ-037 full SHALL be 1 iff the pointer MSBs differ and the low ADDR_W bits are equal.
REQ-038 empty, full and count SHALL be registered or derived only from registered pointers.
REQ-039 overflow SHALL be registered: 1 in the cycle after (wr_en & full).
REQ-040 underflow SHALL be registered: 1 in the cycle after (rd_en & empty).
REQ-041 Same-cycle read and write to one RAM address SHALL never be issued; REQ-023/024 guarantee this, and no bypass path exists.
REQ-042 Data SHALL be read out in strict write order; no word is lost or duplicated across pointer wrap.

Reset
REQ-043 rst_n=0 SHALL immediately, without a clock edge, force: wr_ptr=0, rd_ptr=0, empty=1, full=0, count=0, rd_valid=0, overflow=0, underflow=0.
REQ-044 Reset mid-operation SHALL discard all stored words; RAM contents are not cleared.
REQ-045 An rd_valid strobe pending at reset SHALL be suppressed.
REQ-046 The first accepted operation is possible on the first rising edge after rst_n deasserts.

Verification
REQ-047 Reset then 64 writes of 0x00..0x3F -> count 64, full=1, empty=0; a 65th write -> overflow pulses once, count stays 64.
REQ-048 From full, 64 reads -> rd_data 0x00..0x3F in order, each with rd_valid one cycle after rd_en; then empty=1; one more read -> underflow pulse, no rd_valid.
REQ-049 Wrap: write 40, read 40, write 50, read 50 -> the 50 words return in order across the address 63->0 boundary; empty=1 at the end.
REQ-050 Simultaneous wr_en and rd_en at count=10 for 20 cycles -> count stays 10; data returns in order.
REQ-051 Simultaneous wr_en and rd_en at count=0 -> write accepted, read rejected with an underflow pulse, count 1.
REQ-052 Simultaneous wr_en and rd_en at count=64 -> read accepted, write rejected with an overflow pulse, count 63.
REQ-053 rst_n asserted at count=30 between clock edges -> count=0, empty=1, rd_valid=0 immediately; a subsequent write/read of 0xA5 returns 0xA5.
